// File: rtl/draw_sequencer_if.sv
// Engine-side and display-side signal bundle for draw_sequencer.
// The sequencer takes the slave view; whatever drives the engines takes the master view.
interface draw_sequencer_if;
  logic        frame_tick;

  logic [15:0] map_rom_addr;
  logic        map_plot;
  logic [7:0]  map_x;
  logic [6:0]  map_y;
  logic [23:0] map_rgb;
  logic        map_done;

  logic [15:0] tile_rom_addr;
  logic        tile_plot;
  logic [7:0]  tile_x;
  logic [6:0]  tile_y;
  logic [23:0] tile_rgb;
  logic        tile_done;

  logic        map_start;
  logic        tile_start;
  logic [15:0] rom_addr;
  logic        vga_plot;
  logic [7:0]  vga_x;
  logic [6:0]  vga_y;
  logic [23:0] vga_rgb;
  logic        busy;
  logic [7:0]  overrun_cnt;
  logic        wd_flag;

  modport slave (
    input  frame_tick,
    input  map_rom_addr, map_plot, map_x, map_y, map_rgb, map_done,
    input  tile_rom_addr, tile_plot, tile_x, tile_y, tile_rgb, tile_done,
    output map_start, tile_start, rom_addr,
    output vga_plot, vga_x, vga_y, vga_rgb,
    output busy, overrun_cnt, wd_flag
  );

  modport master (
    output frame_tick,
    output map_rom_addr, map_plot, map_x, map_y, map_rgb, map_done,
    output tile_rom_addr, tile_plot, tile_x, tile_y, tile_rgb, tile_done,
    input  map_start, tile_start, rom_addr,
    input  vga_plot, vga_x, vga_y, vga_rgb,
    input  busy, overrun_cnt, wd_flag
  );
endinterface

// File: rtl/draw_sequencer.sv
// Per-frame map-then-tile draw scheduler; muxes ROM address and VGA pixel bus to the owning engine.
// Optional watchdog on the WAIT states is enabled with `define DRAW_WATCHDOG_EN.
module draw_sequencer #(
  parameter int WATCHDOG_CYCLES = 700000
) (
  input  logic          clk,
  input  logic          resetn,
  draw_sequencer_if.slave bus
);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_MAP_START,
    ST_MAP_WAIT,
    ST_TILE_START,
    ST_TILE_WAIT
  } state_e;

  // Timeout must fit the 20-bit counter and stay below one frame period.
  if (WATCHDOG_CYCLES < 2 || WATCHDOG_CYCLES > 833332) begin : g_wd_range_err
    $error("draw_sequencer: WATCHDOG_CYCLES out of range");
  end

  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

  state_e      state_q, state_d;
  logic [7:0]  overrun_q, overrun_d;
  logic        cur_done;
  logic        wd_fire;
  logic        own_map, own_tile;

  logic        vga_plot_q, vga_plot_d;
  logic [7:0]  vga_x_q, vga_x_d;
  logic [6:0]  vga_y_q, vga_y_d;
  logic [23:0] vga_rgb_q, vga_rgb_d;

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE:       if (bus.frame_tick) state_d = ST_MAP_START;
      ST_MAP_START:  state_d = ST_MAP_WAIT;
      ST_MAP_WAIT:   if (bus.map_done || wd_fire) state_d = ST_TILE_START;
      ST_TILE_START: state_d = ST_TILE_WAIT;
      ST_TILE_WAIT:  if (bus.tile_done || wd_fire) state_d = ST_IDLE;
      default:       state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    own_map        = (state_q == ST_MAP_START)  || (state_q == ST_MAP_WAIT);
    own_tile       = (state_q == ST_TILE_START) || (state_q == ST_TILE_WAIT);
    cur_done       = ((state_q == ST_MAP_WAIT)  && bus.map_done) ||
                     ((state_q == ST_TILE_WAIT) && bus.tile_done);
    bus.map_start  = (state_q == ST_MAP_START);
    bus.tile_start = (state_q == ST_TILE_START);
    bus.busy       = (state_q != ST_IDLE);

    // ROM address is unregistered so each engine keeps its own read latency.
    bus.rom_addr = 16'd0;
    vga_plot_d   = 1'b0;
    vga_x_d      = 8'd0;
    vga_y_d      = 7'd0;
    vga_rgb_d    = 24'd0;
    if (own_map) begin
      bus.rom_addr = bus.map_rom_addr;
      vga_plot_d   = bus.map_plot;
      vga_x_d      = bus.map_x;
      vga_y_d      = bus.map_y;
      vga_rgb_d    = bus.map_rgb;
    end else if (own_tile) begin
      bus.rom_addr = bus.tile_rom_addr;
      vga_plot_d   = bus.tile_plot;
      vga_x_d      = bus.tile_x;
      vga_y_d      = bus.tile_y;
      vga_rgb_d    = bus.tile_rgb;
    end

    overrun_d = overrun_q;
    if (bus.frame_tick && (state_q != ST_IDLE)) overrun_d = sat_inc8(overrun_q);
  end

  // Whole pixel bus is registered as one word so plot/x/y/rgb never split across owners.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      vga_plot_q <= 1'b0;
      vga_x_q    <= 8'd0;
      vga_y_q    <= 7'd0;
      vga_rgb_q  <= 24'd0;
      overrun_q  <= 8'd0;
    end else begin
      vga_plot_q <= vga_plot_d;
      vga_x_q    <= vga_x_d;
      vga_y_q    <= vga_y_d;
      vga_rgb_q  <= vga_rgb_d;
      overrun_q  <= overrun_d;
    end
  end

  assign bus.vga_plot    = vga_plot_q;
  assign bus.vga_x       = vga_x_q;
  assign bus.vga_y       = vga_y_q;
  assign bus.vga_rgb     = vga_rgb_q;
  assign bus.overrun_cnt = overrun_q;

`ifdef DRAW_WATCHDOG_EN
  localparam logic [19:0] WD_LAST = 20'(WATCHDOG_CYCLES - 1);

  logic [19:0] wd_cnt_q, wd_cnt_d;
  logic        wd_flag_q, wd_flag_d;
  logic        in_wait;

  // Counter restarts whenever the FSM is outside a WAIT state, i.e. on every WAIT entry.
  always_comb begin
    in_wait   = (state_q == ST_MAP_WAIT) || (state_q == ST_TILE_WAIT);
    wd_fire   = in_wait && !cur_done && (wd_cnt_q == WD_LAST);
    wd_cnt_d  = in_wait ? wd_cnt_q + 20'd1 : 20'd0;
    wd_flag_d = wd_flag_q | wd_fire;
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      wd_cnt_q  <= 20'd0;
      wd_flag_q <= 1'b0;
    end else begin
      wd_cnt_q  <= wd_cnt_d;
      wd_flag_q <= wd_flag_d;
    end
  end

  assign bus.wd_flag = wd_flag_q;
`else
  logic unused_done;
  assign unused_done = cur_done;
  assign wd_fire     = 1'b0;
  assign bus.wd_flag = 1'b0;
`endif

endmodule

// File: tb/tb_draw_sequencer.sv
// Directed bench for draw_sequencer: frame-level reference model checked every cycle,
// plus hand-computed checks of latencies, counts and saturation.
`timescale 1ns/1ps
module tb_draw_sequencer;
  localparam int WD = 50;
`ifdef DRAW_WATCHDOG_EN
  localparam bit WD_EN = 1'b1;
`else
  localparam bit WD_EN = 1'b0;
`endif

  logic clk = 1'b0;
  logic resetn = 1'b0;
  draw_sequencer_if bus();

  draw_sequencer #(.WATCHDOG_CYCLES(WD)) dut (
    .clk(clk),
    .resetn(resetn),
    .bus(bus)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Engine data: both engines plot continuously with distinguishable payloads.
  logic [11:0] dcnt = 12'd0;
  initial begin
    bus.map_plot = 1'b1;  bus.map_x = 8'h11;  bus.map_y = 7'h05;
    bus.tile_plot = 1'b1; bus.tile_x = 8'h22; bus.tile_y = 7'h0A;
    bus.map_rom_addr = {4'h1, dcnt};  bus.map_rgb = {12'hA5A, dcnt};
    bus.tile_rom_addr = {4'h8, dcnt}; bus.tile_rgb = {12'h5A5, dcnt};
    forever begin
      @(posedge clk);
      #3;
      dcnt = dcnt + 12'd1;
      bus.map_rom_addr  = {4'h1, dcnt};
      bus.map_rgb       = {12'hA5A, dcnt};
      bus.tile_rom_addr = {4'h8, dcnt};
      bus.tile_rgb      = {12'h5A5, dcnt};
    end
  end

  // Frame-level model: 0 idle, 1 map start, 2 map drawing, 3 tile start, 4 tile drawing.
  int          m_phase = 0;
  int          m_ovr   = 0;
  int          m_wait  = 0;
  bit          m_wd    = 1'b0;
  logic        m_plot  = 1'b0;
  logic [7:0]  m_x     = '0;
  logic [6:0]  m_y     = '0;
  logic [23:0] m_rgb   = '0;
  logic [15:0] exp_rom;
  bit          s_tick, s_mdone, s_tdone, timeout;

  int cyc = 0, ms_cnt = 0, ts_cnt = 0, busy_cnt = 0, ms_cyc = 0, ts_cyc = 0;

  always @(posedge clk) begin
    s_tick  = bus.frame_tick;
    s_mdone = bus.map_done;
    s_tdone = bus.tile_done;
    if (!resetn) begin
      m_phase = 0; m_ovr = 0; m_wait = 0; m_wd = 1'b0;
      m_plot = 1'b0; m_x = '0; m_y = '0; m_rgb = '0;
    end else begin
      if (m_phase == 1 || m_phase == 2) begin
        m_plot = bus.map_plot; m_x = bus.map_x; m_y = bus.map_y; m_rgb = bus.map_rgb;
      end else if (m_phase == 3 || m_phase == 4) begin
        m_plot = bus.tile_plot; m_x = bus.tile_x; m_y = bus.tile_y; m_rgb = bus.tile_rgb;
      end else begin
        m_plot = 1'b0; m_x = '0; m_y = '0; m_rgb = '0;
      end
      if (s_tick && m_phase != 0 && m_ovr < 255) m_ovr++;
      case (m_phase)
        0: if (s_tick) m_phase = 1;
        1: begin m_phase = 2; m_wait = 0; end
        2: begin
          m_wait++;
          timeout = WD_EN && (m_wait >= WD) && !s_mdone;
          if (timeout) m_wd = 1'b1;
          if (s_mdone || timeout) m_phase = 3;
        end
        3: begin m_phase = 4; m_wait = 0; end
        default: begin
          m_wait++;
          timeout = WD_EN && (m_wait >= WD) && !s_tdone;
          if (timeout) m_wd = 1'b1;
          if (s_tdone || timeout) m_phase = 0;
        end
      endcase
    end
    #1;
    cyc++;
    if (bus.map_start === 1'b1) begin ms_cnt++; ms_cyc = cyc; end
    if (bus.tile_start === 1'b1) begin ts_cnt++; ts_cyc = cyc; end
    if (bus.busy === 1'b1) busy_cnt++;
    if (m_phase == 1 || m_phase == 2)      exp_rom = bus.map_rom_addr;
    else if (m_phase == 3 || m_phase == 4) exp_rom = bus.tile_rom_addr;
    else                                   exp_rom = 16'd0;
    check("cyc_map_start",  bus.map_start,  m_phase == 1);
    check("cyc_tile_start", bus.tile_start, m_phase == 3);
    check("cyc_busy",       bus.busy,       m_phase != 0);
    check("cyc_rom_addr",   bus.rom_addr,   exp_rom);
    check("cyc_vga_plot",   bus.vga_plot,   m_plot);
    check("cyc_vga_x",      bus.vga_x,      m_x);
    check("cyc_vga_y",      bus.vga_y,      m_y);
    check("cyc_vga_rgb",    bus.vga_rgb,    m_rgb);
    check("cyc_overrun",    bus.overrun_cnt, m_ovr);
    check("cyc_wd_flag",    bus.wd_flag,    m_wd);
  end

  // which: 0 map_start, 1 tile_start, 2 idle. Checks the current cycle first.
  task automatic wait_sig(input int which, input int limit, output bit found);
    found = 1'b0;
    for (int i = 0; i < limit; i++) begin
      if ((which == 0 && bus.map_start === 1'b1) ||
          (which == 1 && bus.tile_start === 1'b1) ||
          (which == 2 && bus.busy === 1'b0)) begin
        found = 1'b1;
        return;
      end
      @(negedge clk);
    end
  endtask

  task automatic tick_pulse();
    bus.frame_tick = 1'b1;
    @(negedge clk);
    bus.frame_tick = 1'b0;
  endtask

  task automatic do_reset();
    resetn = 1'b0;
    bus.frame_tick = 1'b0; bus.map_done = 1'b0; bus.tile_done = 1'b0;
    repeat (2) @(negedge clk);
    resetn = 1'b1;
    ms_cnt = 0; ts_cnt = 0; busy_cnt = 0;
  endtask

  task automatic drain(input string name);
    bit f;
    bus.map_done = 1'b1; bus.tile_done = 1'b1;
    wait_sig(2, 4 * WD + 20, f);
    bus.map_done = 1'b0; bus.tile_done = 1'b0;
    check(name, f, 1'b1);
  endtask

  bit f;

  initial begin
    bus.frame_tick = 1'b0; bus.map_done = 1'b0; bus.tile_done = 1'b0;

    // Reset state while both engines plot
    repeat (2) @(negedge clk);
    check("rst_vga_plot", bus.vga_plot, 1'b0);
    check("rst_vga_x",    bus.vga_x,    8'h00);
    check("rst_rom_addr", bus.rom_addr, 16'h0000);
    check("rst_busy",     bus.busy,     1'b0);
    check("rst_overrun",  bus.overrun_cnt, 8'd0);
    check("rst_wd_flag",  bus.wd_flag,  1'b0);
    do_reset();

    // Single frame: map_done 100 cycles after map_start, tile_done 64 after tile_start
    tick_pulse();
    wait_sig(0, 10, f);
    check("t1_map_start_seen", f, 1'b1);
    repeat (50) @(negedge clk);
    check("t1_map_vga_x",   bus.vga_x, 8'h11);
    check("t1_map_plot",    bus.vga_plot, 1'b1);
    check("t1_map_rom",     bus.rom_addr, bus.map_rom_addr);
    repeat (50) @(negedge clk);
    bus.map_done = 1'b1;
    @(negedge clk);
    bus.map_done = 1'b0;
    wait_sig(1, 10, f);
    check("t1_tile_start_seen", f, 1'b1);
    repeat (32) @(negedge clk);
    check("t1_tile_vga_x",  bus.vga_x, 8'h22);
    check("t1_tile_rom",    bus.rom_addr, bus.tile_rom_addr);
    repeat (32) @(negedge clk);
    bus.tile_done = 1'b1;
    @(negedge clk);
    bus.tile_done = 1'b0;
    wait_sig(2, 10, f);
    check("t1_idle_seen",   f, 1'b1);
    check("t1_busy_cycles", busy_cnt, 166);
    check("t1_map_starts",  ms_cnt, 1);
    check("t1_tile_starts", ts_cnt, 1);
    check("t1_overrun",     bus.overrun_cnt, 8'd0);
    @(negedge clk);
    check("t1_idle_plot",   bus.vga_plot, 1'b0);
    check("t1_idle_rom",    bus.rom_addr, 16'h0000);

    // Overrun: 3 dropped ticks, then saturation under a long tick burst
    do_reset();
    tick_pulse();
    wait_sig(0, 10, f);
    check("t2_map_start_seen", f, 1'b1);
    repeat (3) begin
      @(negedge clk);
      tick_pulse();
    end
    check("t2_overrun_3", bus.overrun_cnt, 8'd3);
    bus.frame_tick = 1'b1;
    repeat (300) @(negedge clk);
    bus.frame_tick = 1'b0;
    @(negedge clk);
    check("t2_overrun_sat", bus.overrun_cnt, 8'd255);
`ifndef DRAW_WATCHDOG_EN
    check("t2_single_map_start", ms_cnt, 1);
    check("t2_still_busy", bus.busy, 1'b1);
`endif
    drain("t2_drain");

    // Tick and tile_done together in TILE_WAIT; also the 4-cycle minimum frame
    do_reset();
    tick_pulse();
    wait_sig(0, 10, f);
    check("t3_map_start_seen", f, 1'b1);
    @(negedge clk);
    bus.map_done = 1'b1;
    @(negedge clk);
    bus.map_done = 1'b0;
    check("t3_tile_start", bus.tile_start, 1'b1);
    bus.tile_done = 1'b1;
    @(negedge clk);
    bus.frame_tick = 1'b1;
    @(negedge clk);
    bus.frame_tick = 1'b0; bus.tile_done = 1'b0;
    check("t3_idle",        bus.busy, 1'b0);
    check("t3_overrun_1",   bus.overrun_cnt, 8'd1);
    check("t3_min_latency", busy_cnt, 4);
    @(negedge clk);
    check("t3_no_map_start", ms_cnt, 1);

    // Watchdog with map_done never asserted
    do_reset();
    tick_pulse();
    wait_sig(0, 10, f);
    check("t4_map_start_seen", f, 1'b1);
    wait_sig(1, 200, f);
`ifdef DRAW_WATCHDOG_EN
    check("t4_wd_tile_start", f, 1'b1);
    check("t4_wd_delay",      ts_cyc - ms_cyc, 51);
    check("t4_wd_flag",       bus.wd_flag, 1'b1);
    wait_sig(2, 200, f);
    check("t4_wd_idle",       f, 1'b1);
    @(negedge clk);
    check("t4_wd_sticky",     bus.wd_flag, 1'b1);
`else
    check("t4_no_tile_start", f, 1'b0);
    check("t4_stuck_busy",    bus.busy, 1'b1);
    check("t4_wd_flag_off",   bus.wd_flag, 1'b0);
    drain("t4_drain");
`endif

    // Reset during TILE_WAIT while tile engine plots
    do_reset();
    tick_pulse();
    wait_sig(0, 10, f);
    check("t5_map_start_seen", f, 1'b1);
    @(negedge clk);
    tick_pulse();
    bus.map_done = 1'b1;
    @(negedge clk);
    bus.map_done = 1'b0;
    @(negedge clk);
    check("t5_pre_overrun", bus.overrun_cnt, 8'd1);
    check("t5_pre_plot",    bus.vga_plot, 1'b1);
    check("t5_pre_x",       bus.vga_x, 8'h22);
    resetn = 1'b0;
    @(negedge clk);
    check("t5_rst_busy",    bus.busy, 1'b0);
    check("t5_rst_plot",    bus.vga_plot, 1'b0);
    check("t5_rst_x",       bus.vga_x, 8'h00);
    check("t5_rst_rgb",     bus.vga_rgb, 24'h0);
    check("t5_rst_rom",     bus.rom_addr, 16'h0000);
    check("t5_rst_overrun", bus.overrun_cnt, 8'd0);
    check("t5_rst_starts",  {bus.map_start, bus.tile_start}, 2'b00);
    resetn = 1'b1;
    tick_pulse();
    check("t5_restart", bus.map_start, 1'b1);
    drain("t5_drain");

    repeat (3) @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
